scan_mux: RTL

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 27 ++
 rtl/scan_prescaler.sv | 52 +++++
 rtl/scan_mux.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
//
// Purpose:
//   Shared constants for the scan multiplexer slice: default geometry and
//   timing for scan_mux / scan_prescaler, and the MODE input encoding.
//
// Contents:
//   NUM_CH_DEF        default number of input channels
//   WIDTH_DEF         default bits per channel
//   DIV_DEF           default clock cycles per scan tick
//   BLANK_CYCLES_DEF  default anti-ghosting blank length
//   mode_e            MODE_AUTO = 0 (prescaled scan), MODE_MANUAL = 1 (CTRL select)
// -----------------------------------------------------------------------------
package scan_mux_pkg;

   localparam int unsigned NUM_CH_DEF       = 4;
   localparam int unsigned WIDTH_DEF        = 5;
   localparam int unsigned DIV_DEF          = 100000;
   localparam int unsigned BLANK_CYCLES_DEF = 16;

   typedef enum logic {
      MODE_AUTO   = 1'b0,
      MODE_MANUAL = 1'b1
   } mode_e;

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
//
// Purpose:
//   Free-running modulo-DIV counter that raises TICK for the single cycle in
//   which the count sits at DIV-1. CLR restarts the count at 0 on the next edge
//   and takes priority over the wrap.
//
// Parameters:
//   DIV      cycles per tick (>= 2)
//
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset (count -> 0)
//   CLR      synchronous clear of the count
//   TICK     high while the count equals DIV-1
// -----------------------------------------------------------------------------
module scan_prescaler
   import scan_mux_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEF
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (CLR || (r_cnt == LAST)) begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign TICK = (r_cnt == LAST);

endmodule

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//
// Purpose:
//   Time-multiplexes NUM_CH data channels onto one WIDTH-bit output, e.g. for
//   driving a multiplexed 7-segment display. In auto mode the active channel
//   advances to the next enabled channel once per prescaler tick; in manual
//   mode the channel is taken from CTRL every cycle. All outputs are
//   registered and change together one cycle after the selecting event.
//
// Optional feature:
//   SCAN_MUX_BLANK_EN  when defined, SEL is forced to 0 for BLANK_CYCLES cycles
//                      after every channel change (OUT still updates at once)
//                      to suppress ghosting on the display.
//
// Parameters:
//   NUM_CH        number of channels (2..16)
//   WIDTH         bits per channel
//   DIV           clock cycles per scan tick (>= 2)
//   BLANK_CYCLES  blank length after a change (< DIV), blanking build only
//
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   MODE     0 = auto scan, 1 = manual select
//   CTRL     manual channel index
//   IN       flat data bus, channel k at IN[k*WIDTH +: WIDTH]
//   EN_MASK  per-channel enable, 0 = skip / blank the channel
//   OUT      selected channel data (0 when the selection is invalid/masked)
//   SEL      one-hot active-channel strobe (0 when invalid/masked/blanked)
//   SEL_IDX  current channel index
//   STROBE   one-cycle pulse in the cycle SEL_IDX takes a new value
// -----------------------------------------------------------------------------
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int unsigned NUM_CH       = NUM_CH_DEF,
   parameter int unsigned WIDTH        = WIDTH_DEF,
   parameter int unsigned DIV          = DIV_DEF,
   parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
   localparam int unsigned IW          = $clog2(NUM_CH)
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    MODE,
   input  logic [IW-1:0]           CTRL,
   input  logic [NUM_CH*WIDTH-1:0] IN,
   input  logic [NUM_CH-1:0]       EN_MASK,
   output logic [WIDTH-1:0]        OUT,
   output logic [NUM_CH-1:0]       SEL,
   output logic [IW-1:0]           SEL_IDX,
   output logic                    STROBE
);

   // Elaboration-time parameter sanity checks.
   if ((NUM_CH < 2) || (NUM_CH > 16)) begin : g_bad_num_ch
      $error("scan_mux: NUM_CH must be in 2..16");
   end
   if (DIV < 2) begin : g_bad_div
      $error("scan_mux: DIV must be at least 2");
   end
   if (BLANK_CYCLES >= DIV) begin : g_bad_blank
      $error("scan_mux: BLANK_CYCLES must be below DIV");
   end

   mode_e               w_mode;
   mode_e               r_mode;
   logic                w_clr;
   logic                w_tick;
   logic                w_adv;

   logic [IW-1:0]       r_idx;
   logic [IW-1:0]       w_next;
   logic                w_found;
   logic                w_ctrl_ok;
   logic [IW-1:0]       w_idx_nxt;
   logic                w_valid;
   logic                w_change;

   logic [WIDTH-1:0]    w_data;
   logic [NUM_CH-1:0]   w_onehot;
   logic [NUM_CH-1:0]   w_sel_raw;
   logic [NUM_CH-1:0]   w_sel_gated;

   logic [WIDTH-1:0]    r_out;
   logic [NUM_CH-1:0]   r_sel;
   logic                r_strobe;

   assign w_mode = mode_e'(MODE);

   // Leaving manual mode restarts the prescaler so the first auto advance
   // comes a full DIV cycles later and no stale tick is acted upon.
   assign w_clr = (r_mode == MODE_MANUAL) && (w_mode == MODE_AUTO);

   scan_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .CLR     (w_clr),
      .TICK    (w_tick)
   );

   assign w_adv = w_tick && !w_clr && (w_mode == MODE_AUTO);

   // Next enabled channel strictly after r_idx, wrapping NUM_CH-1 -> 0. The
   // current channel itself is not a candidate, so "only the current channel
   // enabled" and "nothing enabled" both leave w_found low and idx holds.
   always_comb begin
      logic [IW:0] v_sum;
      v_sum   = '0;
      w_found = 1'b0;
      w_next  = r_idx;
      for (int k = 1; k < NUM_CH; k++) begin
         v_sum = {1'b0, r_idx} + (IW+1)'(k);
         if (v_sum >= (IW+1)'(NUM_CH)) begin
            v_sum = v_sum - (IW+1)'(NUM_CH);
         end
         if (!w_found && EN_MASK[v_sum[IW-1:0]]) begin
            w_found = 1'b1;
            w_next  = v_sum[IW-1:0];
         end
      end
   end

   // Only reachable as false when NUM_CH is not a power of two.
   assign w_ctrl_ok = ({1'b0, CTRL} < (IW+1)'(NUM_CH));

   // Channel selected at the coming edge and whether it may be shown.
   always_comb begin
      w_idx_nxt = r_idx;
      w_valid   = 1'b0;
      if (w_mode == MODE_MANUAL) begin
         if (w_ctrl_ok) begin
            w_idx_nxt = CTRL;
         end
         w_valid = w_ctrl_ok && EN_MASK[CTRL];
      end else begin
         if (w_adv && w_found) begin
            w_idx_nxt = w_next;
         end
         w_valid = EN_MASK[w_idx_nxt];
      end
   end

   assign w_change = (w_idx_nxt != r_idx);

   always_comb begin
      w_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_idx_nxt == IW'(k)) begin
            w_data = IN[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_onehot  = {{(NUM_CH-1){1'b0}}, 1'b1} << w_idx_nxt;
   assign w_sel_raw = w_valid ? w_onehot : '0;

`ifdef SCAN_MUX_BLANK_EN
   localparam int unsigned BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

   logic [BW-1:0] r_blank;
   logic [BW-1:0] w_blank_nxt;

   // Reloads on every index change; SEL stays dark while the count is non-zero.
   always_comb begin
      w_blank_nxt = r_blank;
      if (w_change) begin
         w_blank_nxt = BW'(BLANK_CYCLES);
      end else if (r_blank != '0) begin
         w_blank_nxt = r_blank - BW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_blank <= '0;
      end else begin
         r_blank <= w_blank_nxt;
      end
   end

   assign w_sel_gated = (w_blank_nxt != '0) ? '0 : w_sel_raw;
`else
   assign w_sel_gated = w_sel_raw;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_mode   <= MODE_AUTO;
         r_idx    <= '0;
         r_out    <= '0;
         r_sel    <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_mode   <= w_mode;
         r_idx    <= w_idx_nxt;
         r_out    <= w_valid ? w_data : '0;
         r_sel    <= w_sel_gated;
         r_strobe <= w_change;
      end
   end

   assign OUT     = r_out;
   assign SEL     = r_sel;
   assign SEL_IDX = r_idx;
   assign STROBE  = r_strobe;

endmodule
